game_flow_ctrl: RTL
===================

Name: game_flow_ctrl

Overview:
- Parametrised successor of the game top-level control FSM.
- Sequences MENU / GAME / VICTORY / GAME_OVER / MULTI_WAIT and hit-tests up to NUM_BTN on-screen buttons against the mouse position.
- Acts on clicks as rising edges only, and adds a multiplayer-wait timeout.
- Sits between the mouse/UART inputs and the render, game-logic and UART-link blocks.

Parameters:
- NUM_BTN, 3: number of hit-tested buttons.
- BTN_X_POS, {12'd432,12'd432,12'd432}: packed NUM_BTN×12 button x positions; index 0 in the LSBs.
- BTN_Y_POS, {12'd520,12'd540,12'd400}: packed y positions.
- BTN_X_SIZE, {NUM_BTN{12'd128}}: packed widths.
- BTN_Y_SIZE, {NUM_BTN{12'd80}}: packed heights.
- HIT_MARGIN, 10: extra pixels added on the left and top edges of every box.
- PLAY_IDX, 0: index of the PLAY button.
- MULTI_IDX, 1: index of the MULTIPLAYER button.
- MENU_IDX, 2: index of the MENU button, used in MULTI_WAIT.
- WAIT_TIMEOUT, 32'd650_000_000: cycles spent in MULTI_WAIT before giving up; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- game_on  in  1  remote/keyboard request to start the game.
- menu_on  in  1  request to return to the menu.
- game_over  in  1  player lost.
- victory  in  1  player won.
- xpos  in  12  mouse x position.
- ypos  in  12  mouse y position.
- mouse_left  in  1  left-button level.
- opponent_ready  in  1  remote player ready (level).
- pause_req  in  1  pause toggle pulse; present only with CTRL_PAUSE_EN.
- state  out  3  current state: MENU=0, GAME=1, VICTORY=2, GAME_OVER=3, MULTI_WAIT=4, PAUSE=5.
- mouse_mode  out  3  GAME when in GAME, otherwise MENU.
- play_selected  out  1  high in GAME.
- display_buttons_m_and_s  out  1  high in MENU, VICTORY and GAME_OVER.
- display_menu_button  out  1  high in MULTI_WAIT.
- player_ready  out  1  high in MULTI_WAIT.
- multiplayer  out  1  high in MULTI_WAIT, and in GAME when the multiplayer flag is set.
- btn_hover  out  NUM_BTN  registered per-button hit vector.
- wait_timeout  out  1  one-cycle pulse when the MULTI_WAIT timeout expires.

Behaviour:
- Reset: state=MENU; all outputs 0; mouse_mode=MENU; multiplayer flag, click delay register and timeout counter cleared.
- Click detection:
  - click = mouse_left & ~mouse_left_q, where mouse_left_q is registered.
  - A button held through a state change does not re-trigger.
- Hit test for button i (combinational, inclusive bounds, 12-bit compare):
  - x >= X_POS-HIT_MARGIN and x <= X_POS+X_SIZE;
  - y >= Y_POS-HIT_MARGIN and y <= Y_POS+Y_SIZE.
  - If POS < HIT_MARGIN, the lower bound clamps to 0 (no wrap).
  - btn_hover is registered, so it lags the mouse by 1 cycle.
- Outputs are registered from state_nxt, so they are valid in the same cycle as state.
- Transitions, listed in priority order:
  - MENU:
    - game_on → GAME.
    - click on PLAY → GAME, multiplayer flag=0.
    - click on MULTI → MULTI_WAIT, flag=1.
    - game_over → GAME_OVER.
    - victory → VICTORY.
    - otherwise stay.
  - GAME:
    - menu_on → MENU.
    - game_over → GAME_OVER.
    - victory → VICTORY.
    - otherwise stay.
  - VICTORY and GAME_OVER:
    - game_on → GAME.
    - menu_on → MENU.
    - click on PLAY → GAME, flag=0.
    - click on MULTI → MULTI_WAIT, flag=1.
    - click anywhere else → MENU.
    - otherwise stay.
  - MULTI_WAIT:
    - opponent_ready → GAME.
    - click on MENU → MENU, flag=0.
    - timeout → MENU with wait_timeout pulsed, flag=0.
    - otherwise stay.
    - The counter clears on entry and increments each cycle while in this state. Timeout fires in the cycle the counter equals WAIT_TIMEOUT-1.
    - opponent_ready takes priority over a timeout in the same cycle.
  - Illegal encodings → MENU on the next cycle, all outputs 0.
- Overlapping boxes: the lowest index among hit buttons wins.
- game_over and victory asserted together in GAME: game_over wins.

Optional Feature:
- CTRL_PAUSE_EN defined:
  - pause_req in GAME → PAUSE.
  - In PAUSE, pause_req → GAME; menu_on → MENU.
  - PAUSE outputs: mouse_mode=MENU, play_selected=1, multiplayer holds its GAME value.
  - game_over and victory are ignored while paused.
- CTRL_PAUSE_EN undefined: no pause_req port, no PAUSE state, encoding 5 is illegal.

Decomposition:
- Shared package game_ctrl_pkg holds the state encodings, MOUSE_MODE constants, default button geometry and the packed-vector slice helper function. It is shared with the renderer and the UART link.
- One sub-module, btn_hit_test: parametrised by NUM_BTN and the geometry vectors, outputs a hit vector; instantiated once.
- Edge detection, the FSM and the timeout counter live in game_flow_ctrl.

Test Plan:
- Reset, then mouse at (500,440) with mouse_left rising → state=1 one cycle later; play_selected=1, multiplayer=0. Holding mouse_left through to GAME_OVER does not re-trigger.
- Mouse at (422,390), the inclusive corner of PLAY, then at (421,390): click → GAME for (422,390); no transition for (421,390).
- Click MULTI at (500,560) → state=4, player_ready=1. opponent_ready after 100 cycles → state=1, multiplayer=1.
- WAIT_TIMEOUT=50, enter MULTI_WAIT → exactly 50 cycles later state=0, wait_timeout high for 1 cycle. The same test with opponent_ready in cycle 49 → GAME, no pulse.
- In GAME, game_over and victory together → GAME_OVER. Click at (10,10) → MENU. rst mid-GAME → MENU, all outputs 0 next cycle.
- CTRL_PAUSE_EN: GAME with pause_req → PAUSE, then game_over ignored; pause_req → GAME.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: state encodings, mouse modes, default button geometry
// and a packed-vector slice helper shared by control, render and UART link.
package game_ctrl_pkg;

    localparam logic [2:0] ST_MENU       = 3'd0;
    localparam logic [2:0] ST_GAME       = 3'd1;
    localparam logic [2:0] ST_VICTORY    = 3'd2;
    localparam logic [2:0] ST_GAME_OVER  = 3'd3;
    localparam logic [2:0] ST_MULTI_WAIT = 3'd4;
    localparam logic [2:0] ST_PAUSE      = 3'd5;

    localparam logic [2:0] MM_MENU = 3'd0;
    localparam logic [2:0] MM_GAME = 3'd1;

    localparam int MAX_BTN     = 16;
    localparam int DEF_NUM_BTN = 3;

    localparam logic [35:0] DEF_BTN_X_POS  = {12'd432, 12'd432, 12'd432};
    localparam logic [35:0] DEF_BTN_Y_POS  = {12'd520, 12'd540, 12'd400};
    localparam logic [35:0] DEF_BTN_X_SIZE = {3{12'd128}};
    localparam logic [35:0] DEF_BTN_Y_SIZE = {3{12'd80}};

    typedef logic [12*MAX_BTN-1:0] geom_vec_t;

    // Entry idx of a packed 12-bit-per-entry vector, index 0 in the LSBs.
    function automatic logic [11:0] geom_slice(input geom_vec_t vec,
                                               input int idx);
        return 12'(vec >> (idx * 12));
    endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_hit.sv
// btn_hit_test: combinational hit test of the mouse against NUM_BTN boxes.
// Ports: i_xpos/i_ypos mouse position in, o_hit per-button hit vector out.
module btn_hit_test
    import game_ctrl_pkg::*;
#(
    parameter int                    NUM_BTN    = DEF_NUM_BTN,
    parameter logic [12*NUM_BTN-1:0] BTN_X_POS  = DEF_BTN_X_POS,
    parameter logic [12*NUM_BTN-1:0] BTN_Y_POS  = DEF_BTN_Y_POS,
    parameter logic [12*NUM_BTN-1:0] BTN_X_SIZE = DEF_BTN_X_SIZE,
    parameter logic [12*NUM_BTN-1:0] BTN_Y_SIZE = DEF_BTN_Y_SIZE,
    parameter int                    HIT_MARGIN = 10
) (
    input  logic [11:0]        i_xpos,
    input  logic [11:0]        i_ypos,
    output logic [NUM_BTN-1:0] o_hit
);

    localparam geom_vec_t XP_V = geom_vec_t'(BTN_X_POS);
    localparam geom_vec_t YP_V = geom_vec_t'(BTN_Y_POS);
    localparam geom_vec_t XS_V = geom_vec_t'(BTN_X_SIZE);
    localparam geom_vec_t YS_V = geom_vec_t'(BTN_Y_SIZE);
    localparam logic [13:0] MARGIN = 14'(HIT_MARGIN);

    logic [13:0] w_x;
    logic [13:0] w_y;

    assign w_x = {2'b00, i_xpos};
    assign w_y = {2'b00, i_ypos};

    // x >= pos - margin is checked as x + margin >= pos, which also
    // clamps the lower bound at 0 without any wrap-around.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        localparam logic [13:0] XP = {2'b00, geom_slice(XP_V, i)};
        localparam logic [13:0] YP = {2'b00, geom_slice(YP_V, i)};
        localparam logic [13:0] XS = {2'b00, geom_slice(XS_V, i)};
        localparam logic [13:0] YS = {2'b00, geom_slice(YS_V, i)};

        assign o_hit[i] = (w_x + MARGIN >= XP) && (w_x <= XP + XS) &&
                          (w_y + MARGIN >= YP) && (w_y <= YP + YS);
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game top-level flow FSM with button hit test, click edge
// detect and multiplayer-wait timeout. Optional pause via CTRL_PAUSE_EN.
// Ports: clk/rst (sync, active-high), game_on, menu_on, game_over,
// victory, xpos, ypos, mouse_left, opponent_ready, pause_req (pause only)
// in; state, mouse_mode, play_selected, display_buttons_m_and_s,
// display_menu_button, player_ready, multiplayer, btn_hover,
// wait_timeout out. All outputs registered.
module game_flow_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int                    NUM_BTN      = DEF_NUM_BTN,
    parameter logic [12*NUM_BTN-1:0] BTN_X_POS    = DEF_BTN_X_POS,
    parameter logic [12*NUM_BTN-1:0] BTN_Y_POS    = DEF_BTN_Y_POS,
    parameter logic [12*NUM_BTN-1:0] BTN_X_SIZE   = {NUM_BTN{12'd128}},
    parameter logic [12*NUM_BTN-1:0] BTN_Y_SIZE   = {NUM_BTN{12'd80}},
    parameter int                    HIT_MARGIN   = 10,
    parameter int                    PLAY_IDX     = 0,
    parameter int                    MULTI_IDX    = 1,
    parameter int                    MENU_IDX     = 2,
    parameter logic [31:0]           WAIT_TIMEOUT = 32'd650_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_on,
    input  logic               menu_on,
    input  logic               game_over,
    input  logic               victory,
    input  logic [11:0]        xpos,
    input  logic [11:0]        ypos,
    input  logic               mouse_left,
    input  logic               opponent_ready,
`ifdef CTRL_PAUSE_EN
    input  logic               pause_req,
`endif
    output logic [2:0]         state,
    output logic [2:0]         mouse_mode,
    output logic               play_selected,
    output logic               display_buttons_m_and_s,
    output logic               display_menu_button,
    output logic               player_ready,
    output logic               multiplayer,
    output logic [NUM_BTN-1:0] btn_hover,
    output logic               wait_timeout
);

    logic [2:0]         r_state;
    logic               r_flag;
    logic               r_ml_q;
    logic [31:0]        r_cnt;
    logic [NUM_BTN-1:0] r_btn_hover;
    logic [2:0]         r_mouse_mode;
    logic               r_play;
    logic               r_disp_ms;
    logic               r_disp_menu;
    logic               r_player_ready;
    logic               r_multi;
    logic               r_timeout;

    logic [NUM_BTN-1:0] w_hit;
    logic [NUM_BTN-1:0] w_win;
    logic               w_click;
    logic               w_click_play;
    logic               w_click_multi;
    logic               w_click_menu;
    logic               w_to_hit;
    logic [2:0]         w_state_nxt;
    logic               w_flag_nxt;
    logic               w_timeout;
    logic               w_illegal;
    logic               w_in_game;

    btn_hit_test #(
        .NUM_BTN    (NUM_BTN),
        .BTN_X_POS  (BTN_X_POS),
        .BTN_Y_POS  (BTN_Y_POS),
        .BTN_X_SIZE (BTN_X_SIZE),
        .BTN_Y_SIZE (BTN_Y_SIZE),
        .HIT_MARGIN (HIT_MARGIN)
    ) u_hit (
        .i_xpos (xpos),
        .i_ypos (ypos),
        .o_hit  (w_hit)
    );

    // Isolate the lowest set bit so overlapping boxes resolve to the
    // lowest button index.
    assign w_win         = w_hit & (-w_hit);
    assign w_click       = mouse_left & ~r_ml_q;
    assign w_click_play  = w_click & w_win[PLAY_IDX];
    assign w_click_multi = w_click & w_win[MULTI_IDX];
    assign w_click_menu  = w_click & w_win[MENU_IDX];
    assign w_to_hit      = (WAIT_TIMEOUT != 32'd0) &&
                           (r_cnt == WAIT_TIMEOUT - 32'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_flag_nxt  = r_flag;
        w_timeout   = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            ST_MENU: begin
                if (game_on) begin
                    w_state_nxt = ST_GAME;
                end else if (w_click_play) begin
                    w_state_nxt = ST_GAME;
                    w_flag_nxt  = 1'b0;
                end else if (w_click_multi) begin
                    w_state_nxt = ST_MULTI_WAIT;
                    w_flag_nxt  = 1'b1;
                end else if (game_over) begin
                    w_state_nxt = ST_GAME_OVER;
                end else if (victory) begin
                    w_state_nxt = ST_VICTORY;
                end
            end
            ST_GAME: begin
                if (menu_on) begin
                    w_state_nxt = ST_MENU;
                end else if (game_over) begin
                    w_state_nxt = ST_GAME_OVER;
                end else if (victory) begin
                    w_state_nxt = ST_VICTORY;
`ifdef CTRL_PAUSE_EN
                end else if (pause_req) begin
                    w_state_nxt = ST_PAUSE;
`endif
                end
            end
            ST_VICTORY, ST_GAME_OVER: begin
                if (game_on) begin
                    w_state_nxt = ST_GAME;
                end else if (menu_on) begin
                    w_state_nxt = ST_MENU;
                end else if (w_click_play) begin
                    w_state_nxt = ST_GAME;
                    w_flag_nxt  = 1'b0;
                end else if (w_click_multi) begin
                    w_state_nxt = ST_MULTI_WAIT;
                    w_flag_nxt  = 1'b1;
                end else if (w_click) begin
                    w_state_nxt = ST_MENU;
                end
            end
            ST_MULTI_WAIT: begin
                if (opponent_ready) begin
                    w_state_nxt = ST_GAME;
                end else if (w_click_menu) begin
                    w_state_nxt = ST_MENU;
                    w_flag_nxt  = 1'b0;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_MENU;
                    w_flag_nxt  = 1'b0;
                    w_timeout   = 1'b1;
                end
            end
`ifdef CTRL_PAUSE_EN
            ST_PAUSE: begin
                if (pause_req) begin
                    w_state_nxt = ST_GAME;
                end else if (menu_on) begin
                    w_state_nxt = ST_MENU;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_MENU;
                w_flag_nxt  = 1'b0;
                w_illegal   = 1'b1;
            end
        endcase
    end

`ifdef CTRL_PAUSE_EN
    assign w_in_game = (w_state_nxt == ST_GAME) ||
                       (w_state_nxt == ST_PAUSE);
`else
    assign w_in_game = (w_state_nxt == ST_GAME);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_MENU;
            r_flag         <= 1'b0;
            r_ml_q         <= 1'b0;
            r_cnt          <= '0;
            r_btn_hover    <= '0;
            r_mouse_mode   <= MM_MENU;
            r_play         <= 1'b0;
            r_disp_ms      <= 1'b0;
            r_disp_menu    <= 1'b0;
            r_player_ready <= 1'b0;
            r_multi        <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flag      <= w_flag_nxt;
            r_ml_q      <= mouse_left;
            r_btn_hover <= w_hit;
            // Counter restarts on every entry into MULTI_WAIT.
            if (r_state == ST_MULTI_WAIT && w_state_nxt == ST_MULTI_WAIT)
                r_cnt <= r_cnt + 32'd1;
            else
                r_cnt <= '0;
            r_mouse_mode   <= (w_state_nxt == ST_GAME) ? MM_GAME : MM_MENU;
            r_play         <= w_in_game;
            r_disp_ms      <= ~w_illegal &&
                              ((w_state_nxt == ST_MENU) ||
                               (w_state_nxt == ST_VICTORY) ||
                               (w_state_nxt == ST_GAME_OVER));
            r_disp_menu    <= (w_state_nxt == ST_MULTI_WAIT);
            r_player_ready <= (w_state_nxt == ST_MULTI_WAIT);
            r_multi        <= (w_state_nxt == ST_MULTI_WAIT) ||
                              (w_in_game && w_flag_nxt);
            r_timeout      <= w_timeout;
        end
    end

    assign state                   = r_state;
    assign mouse_mode              = r_mouse_mode;
    assign play_selected           = r_play;
    assign display_buttons_m_and_s = r_disp_ms;
    assign display_menu_button     = r_disp_menu;
    assign player_ready            = r_player_ready;
    assign multiplayer             = r_multi;
    assign btn_hover               = r_btn_hover;
    assign wait_timeout            = r_timeout;

endmodule
